gold_fill_ctrl: RTL and testbench
=================================

Name: gold_fill_ctrl

Overview:
Upstream controller for the gold-code sub-generator A delay-line LFSR (26-stage, tap at 4). It accepts a parallel seed over a valid/ready handshake and shifts it in serially, one bit per cycle, with Fill_En_A high. It then releases the generator to free-run under a Run gate. While free-running it counts chips and flags each code epoch boundary.

Parameters:
FILL_LEN, 26, number of fill bits; equals the generator's longest delay length.
CNT_W, 5, width of the fill bit index; must satisfy 2^CNT_W >= FILL_LEN.
EPOCH_LEN, 1023, free-run chips per epoch.
EP_W, 10, width of Chip_Cnt; must satisfy 2^EP_W >= EPOCH_LEN.

Ports:
Clock  input  1  system clock, rising edge.
Reset_n  input  1  asynchronous active-low reset.
Load_Valid  input  1  Seed presented for loading.
Seed  input  FILL_LEN  parallel initial fill; Seed[0] is shifted first.
Run  input  1  free-run gate, sampled only in RUN.
Load_Ready  output  1  controller can accept a seed.
Enable  output  1  generator shift enable; drives the sub-generator Enable.
Fill_En_A  output  1  fill-mode select to the generator.
New_Fill_A  output  1  serial fill bit to the generator.
Busy  output  1  high while in FILL.
Fill_Done  output  1  one-cycle pulse on entry to RUN.
Seed_Err  output  1  one-cycle pulse when an all-zero seed is rejected.
Chip_Cnt  output  EP_W  chips generated in the current epoch.
Epoch  output  1  high on the last chip of an epoch.

Behaviour:
- Reset: Reset_n low forces IDLE asynchronously.
  - Registered outputs go to 0: Fill_En_A, New_Fill_A, Fill_Done, Seed_Err, Chip_Cnt, bit index, seed register.
  - Load_Ready=1 in reset. Enable=0, Busy=0, Epoch=0.
- States:
  - IDLE: Load_Ready=1, Enable=0.
  - FILL: Load_Ready=0, Busy=1, Enable=1, Fill_En_A=1.
  - RUN: Load_Ready=1, Enable=Run, Fill_En_A=0.
- Enable, Busy, Load_Ready and Epoch are combinational from state, Run and Chip_Cnt. All other outputs are registered.
- Handshake: a seed is accepted on a rising edge with Load_Valid=1 and Load_Ready=1. Seed is captured into an internal shift register.
- Accept (nonzero seed), from IDLE or RUN:
  - Next state FILL; bit index=0; Chip_Cnt=0.
  - Fill_En_A=1 and New_Fill_A=Seed[0] from the following cycle.
  - A load in RUN aborts the current run immediately; there is no wait for the epoch boundary.
- All-zero seed (LFSR lock-up value):
  - The handshake still completes (Load_Ready is not withdrawn).
  - State, seed register and Chip_Cnt are unchanged.
  - Seed_Err=1 in the following cycle only.
- FILL:
  - Each cycle, New_Fill_A presents Seed[k], k=0..FILL_LEN-1. Exactly FILL_LEN consecutive cycles with Enable=1 and Fill_En_A=1.
  - After the fill, the generator's last stage holds Seed[0], so the first run chip equals Seed[0].
  - Load_Valid is ignored during FILL.
- End of fill: on the edge that ends bit FILL_LEN-1, state goes to RUN, Fill_En_A=0, New_Fill_A=0, and Fill_Done=1 for that first RUN cycle.
- RUN:
  - Each cycle with Run=1 is one chip. Chip_Cnt increments on that edge.
  - Epoch=1 when Run=1 and Chip_Cnt=EPOCH_LEN-1. On that edge Chip_Cnt wraps to 0.
  - Run=0 holds Chip_Cnt and the generator state (Enable=0).
- Simultaneous Load accept and Run=1 in RUN: the load wins. That cycle still shifts (Enable=Run) and still counts. The next cycle is FILL with Chip_Cnt=0.
- Reset during FILL: immediate return to IDLE. Generator contents are then undefined and must be refilled. No Fill_Done is issued.

Test Plan:
1. Reset, then load Seed=26'h0000001 -> 26 cycles with Enable=Fill_En_A=1; New_Fill_A=1 in the first cycle, 0 after. Fill_Done in cycle 27. Generator's first output chip=1.
2. Load Seed=0 in IDLE -> Seed_Err pulses 1 cycle; state stays IDLE; Enable stays 0.
3. After a fill, hold Run=1 for 1023 cycles -> Epoch high only on cycle 1023; Chip_Cnt reads 1022 then 0.
4. Toggle Run 1/0 every cycle for 20 cycles -> Chip_Cnt=10; Enable mirrors Run.
5. Assert Load_Valid with Seed=26'h2AAAAAA at Chip_Cnt=500 in RUN -> FILL next cycle; Chip_Cnt=0; New_Fill_A sequence 0,1,0,1,...
6. Pull Reset_n low at fill bit 13 -> outputs zero asynchronously; no Fill_Done; Load_Ready=1 after release.

Source files
------------

// File: rtl/gold_fill_ctrl.sv
// gold_fill_ctrl: loads a parallel seed into the sub-generator A delay line
// one bit per cycle, then gates its free run and counts chips per epoch.
module gold_fill_ctrl #(
  parameter int FILL_LEN  = 26,
  parameter int CNT_W     = 5,
  parameter int EPOCH_LEN = 1023,
  parameter int EP_W      = 10
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                Load_Valid,
  input  logic [FILL_LEN-1:0] Seed,
  input  logic                Run,
  output logic                Load_Ready,
  output logic                Enable,
  output logic                Fill_En_A,
  output logic                New_Fill_A,
  output logic                Busy,
  output logic                Fill_Done,
  output logic                Seed_Err,
  output logic [EP_W-1:0]     Chip_Cnt,
  output logic                Epoch
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FILL_LEN - 1);
  localparam logic [EP_W-1:0]  LAST_CHIP = EP_W'(EPOCH_LEN - 1);

  state_t              state_q;
  logic [FILL_LEN-1:0] seed_q;
  logic [CNT_W-1:0]    idx_q;
  logic                fill_en_q;
  logic                new_fill_q;
  logic                fill_done_q;
  logic                seed_err_q;
  logic [EP_W-1:0]     chip_cnt_q;

  logic in_fill;
  logic in_run;
  logic chip;

  assign in_fill = (state_q == FILL);
  assign in_run  = (state_q == RUN);
  // A chip is any RUN cycle with the gate open; the generator shifts on it.
  assign chip    = in_run & Run;

  // Handshake, state and control outputs that depend only on state/Run/count.
  assign Load_Ready = ~in_fill;
  assign Busy       = in_fill;
  assign Enable     = in_fill | chip;
  assign Epoch      = chip & (chip_cnt_q == LAST_CHIP);

  assign Fill_En_A  = fill_en_q;
  assign New_Fill_A = new_fill_q;
  assign Fill_Done  = fill_done_q;
  assign Seed_Err   = seed_err_q;
  assign Chip_Cnt   = chip_cnt_q;

  // Fill/run sequencer with registered fill-side outputs and chip counter.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      seed_q      <= '0;
      idx_q       <= '0;
      fill_en_q   <= 1'b0;
      new_fill_q  <= 1'b0;
      fill_done_q <= 1'b0;
      seed_err_q  <= 1'b0;
      chip_cnt_q  <= '0;
    end else begin
      fill_done_q <= 1'b0;
      seed_err_q  <= 1'b0;
      case (state_q)
        IDLE, RUN: begin
          // Counting happens first so an accepted load below overrides it.
          if (chip) begin
            chip_cnt_q <= (chip_cnt_q == LAST_CHIP) ? '0 : chip_cnt_q + 1'b1;
          end
          if (Load_Valid) begin
            if (Seed == '0) begin
              // All-zero fill would lock the LFSR; consume it and flag.
              seed_err_q <= 1'b1;
            end else begin
              state_q    <= FILL;
              seed_q     <= Seed;
              idx_q      <= '0;
              chip_cnt_q <= '0;
              fill_en_q  <= 1'b1;
              new_fill_q <= Seed[0];
            end
          end
        end
        FILL: begin
          if (idx_q == LAST_IDX) begin
            state_q     <= RUN;
            fill_en_q   <= 1'b0;
            new_fill_q  <= 1'b0;
            fill_done_q <= 1'b1;
          end else begin
            // The seed register shifts down so bit 1 is always the next bit.
            idx_q      <= idx_q + 1'b1;
            seed_q     <= seed_q >> 1;
            new_fill_q <= seed_q[1];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gold_fill_ctrl.sv
// Directed bench for gold_fill_ctrl with immediate-assertion checks.
module tb_gold_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid;
  logic [25:0] seed;
  logic        run;
  logic        load_ready, enable, fill_en, new_fill, busy, fill_done, seed_err, epoch;
  logic [9:0]  chip_cnt;

  int checks = 0;
  int errors = 0;

  // Bench-side model of the generator delay line in fill mode.
  logic [25:0] gen = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (enable && fill_en) gen <= {new_fill, gen[25:1]};
  end

  gold_fill_ctrl dut (
    .Clock      (clk),
    .Reset_n    (rst_n),
    .Load_Valid (load_valid),
    .Seed       (seed),
    .Run        (run),
    .Load_Ready (load_ready),
    .Enable     (enable),
    .Fill_En_A  (fill_en),
    .New_Fill_A (new_fill),
    .Busy       (busy),
    .Fill_Done  (fill_done),
    .Seed_Err   (seed_err),
    .Chip_Cnt   (chip_cnt),
    .Epoch      (epoch)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int epoch_hits;
    int epoch_last;
    int done_hits;
    int busy_hits;

    rst_n      = 1'b0;
    load_valid = 1'b0;
    seed       = '0;
    run        = 1'b0;
    #2;
    chk("rst_load_ready", load_ready, 1);
    chk("rst_enable", enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fill_en", fill_en, 0);
    chk("rst_chip_cnt", chip_cnt, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // All-zero seed in IDLE: rejected with a one-cycle error pulse.
    load_valid = 1'b1;
    seed       = '0;
    #1;
    chk("zero_ready", load_ready, 1);
    tick();
    load_valid = 1'b0;
    chk("zero_err_pulse", seed_err, 1);
    chk("zero_busy", busy, 0);
    chk("zero_enable", enable, 0);
    tick();
    chk("zero_err_clear", seed_err, 0);
    chk("zero_still_idle", load_ready & ~busy, 1);
    $display("txn zero_seed: seed_err pulse observed, state idle");

    // Seed 1: one marker bit then zeros, 26 fill cycles.
    load_valid = 1'b1;
    seed       = 26'h0000001;
    tick();
    load_valid = 1'b0;
    chk("f1_en", enable, 1);
    chk("f1_fill_en", fill_en, 1);
    chk("f1_busy", busy, 1);
    chk("f1_ready", load_ready, 0);
    chk("f1_bit0", new_fill, 1);
    for (int k = 1; k < 26; k++) begin
      tick();
      chk($sformatf("f1_bit%0d", k), new_fill, 0);
      chk($sformatf("f1_fe%0d", k), fill_en & enable, 1);
    end
    tick();
    chk("f1_done", fill_done, 1);
    chk("f1_fill_en_off", fill_en, 0);
    chk("f1_run_enable", enable, 0);
    chk("f1_first_chip", gen[0], 1);
    run = 1'b1;
    $display("txn fill seed=0000001: done, first chip=%0d", gen[0]);

    // Full epoch with Run held high.
    epoch_hits = 0;
    epoch_last = 0;
    for (int i = 0; i < 1023; i++) begin
      if (epoch) epoch_hits++;
      if (i == 1022) begin
        epoch_last = epoch;
        chk("ep_cnt_last", chip_cnt, 1022);
      end
      tick();
      if (i == 0) chk("ep_done_clear", fill_done, 0);
    end
    chk("ep_hits", epoch_hits, 1);
    chk("ep_on_last", epoch_last, 1);
    chk("ep_wrap", chip_cnt, 0);
    $display("txn epoch: hits=%0d wrap cnt=%0d", epoch_hits, chip_cnt);

    // Toggle Run each cycle: half of the cycles count.
    for (int i = 0; i < 20; i++) begin
      run = (i % 2 == 0);
      #1;
      chk($sformatf("tog_en%0d", i), enable, run);
      tick();
    end
    chk("tog_cnt", chip_cnt, 10);
    tick();
    tick();
    chk("hold_cnt", chip_cnt, 10);
    $display("txn toggle: chip_cnt=%0d", chip_cnt);

    // Reach 500 chips, then load mid-run with Run still high.
    run = 1'b1;
    repeat (490) tick();
    chk("mid_cnt500", chip_cnt, 500);
    load_valid = 1'b1;
    seed       = 26'h2AAAAAA;
    #1;
    chk("mid_ready", load_ready, 1);
    chk("mid_enable", enable, 1);
    tick();
    seed = 26'h3FFFFFF;  // still valid, must be ignored during FILL
    run  = 1'b0;
    chk("mid_busy", busy, 1);
    chk("mid_cnt_clr", chip_cnt, 0);
    chk("mid_bit0", new_fill, 0);
    for (int k = 1; k <= 13; k++) begin
      tick();
      chk($sformatf("mid_bit%0d", k), new_fill, k % 2);
    end
    load_valid = 1'b0;
    $display("txn reload seed=2AAAAAA: alternating fill through bit 13");

    // Asynchronous reset in the middle of bit 13.
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_fill_en", fill_en, 0);
    chk("ar_new_fill", new_fill, 0);
    chk("ar_busy", busy, 0);
    chk("ar_enable", enable, 0);
    chk("ar_ready", load_ready, 1);
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    chk("ar_ready_rel", load_ready, 1);
    done_hits = 0;
    busy_hits = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (fill_done) done_hits++;
      if (busy) busy_hits++;
    end
    chk("ar_no_done", done_hits, 0);
    chk("ar_no_busy", busy_hits, 0);
    $display("txn async_reset: fill_done count=%0d", done_hits);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
